sda_kernel_action_stub_regs: RTL and testbench

Parametrised stub kernel action for SDAccel builds with no shared-memory access. It provides an AXI4-Lite slave register file with full read/write decode, byte strobes and error responses. A go/done action controller completes each action after a software-programmable delay and counts completed actions. It sits in the kernel action toplevel in place of a real Teak action and is used for host-driver and shell bring-up.

---
 rtl/sda_kernel_action_stub_regs.sv | 245 ++++++++++++++++++++++++
 tb/tb_sda_kernel_action_stub_regs.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sda_kernel_action_stub_regs.sv
// Stub kernel action: AXI4-Lite slave register file plus a go/done action
// controller that completes each action after a programmable delay.
//   reg0 : read-only count of completed actions (wraps)
//   reg1 : action delay D (cycles spent counting down in RUN)
//   reg2+: read/write scratch
module sda_kernel_action_stub_regs #(
    parameter int ADDR_WIDTH         = 32,
    parameter int DATA_WIDTH         = 32,
    parameter int NUM_REGS           = 16,
    parameter int DONE_DELAY_DEFAULT = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      go_0r,
    output logic                      go_0a,
    output logic                      done_0r,
    input  logic                      done_0a,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LSB        = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = $clog2(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // Register file
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    // Write channel state
    logic                  aw_held_q;
    logic                  w_held_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;

    // Read channel state
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    // Action controller state
    state_t                state_q;
    logic [DATA_WIDTH-1:0] counter_q;
    logic                  go_0a_q;
    logic                  done_0r_q;

    // Handshakes and decode
    logic                  aw_fire;
    logic                  w_fire;
    logic                  ar_fire;
    logic                  wr_exec;
    logic [ADDR_WIDTH-1:0] wr_word;
    logic [ADDR_WIDTH-1:0] rd_word;
    logic [IDX_WIDTH-1:0]  wr_idx;
    logic [IDX_WIDTH-1:0]  rd_idx;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  count_inc;
    logic [DATA_WIDTH-1:0] wr_merged_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [1:0]            rresp_d;
    logic [DATA_WIDTH-1:0] count_d;

    assign s_axi_awready = ~aw_held_q & ~bvalid_q;
    assign s_axi_wready  = ~w_held_q & ~bvalid_q;
    assign s_axi_arready = ~rvalid_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign go_0a         = go_0a_q;
    assign done_0r       = done_0r_q;

    assign aw_fire = s_axi_awvalid & s_axi_awready;
    assign w_fire  = s_axi_wvalid & s_axi_wready;
    assign ar_fire = s_axi_arvalid & s_axi_arready;

    // The write is performed in the cycle where both address and data are held
    assign wr_exec = aw_held_q & w_held_q;

    // Word index: byte-lane address bits are dropped
    assign wr_word     = awaddr_q >> LSB;
    assign rd_word     = s_axi_araddr >> LSB;
    assign wr_in_range = wr_word < ADDR_WIDTH'(NUM_REGS);
    assign rd_in_range = rd_word < ADDR_WIDTH'(NUM_REGS);
    assign wr_idx      = wr_word[IDX_WIDTH-1:0];
    assign rd_idx      = rd_word[IDX_WIDTH-1:0];

    // Count advances when software acknowledges a finished action
    assign count_inc = (state_q == ST_DONE) & done_0a;
    assign count_d   = regs_q[0] + DATA_WIDTH'(1);

    // Merge held write data into the target register under the byte strobes
    always_comb begin
        wr_merged_d = regs_q[wr_idx];
        for (int b = 0; b < STRB_WIDTH; b++) begin
            if (wstrb_q[b]) begin
                wr_merged_d[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    // Read data mux; out-of-range reads return zero with SLVERR
    always_comb begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
        if (rd_in_range) begin
            rdata_d = regs_q[rd_idx];
            rresp_d = RESP_OKAY;
        end
    end

    // Write channel: hold AW and W independently, execute once both are held
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_fire) begin
                aw_held_q <= 1'b1;
                awaddr_q  <= s_axi_awaddr;
            end
            if (w_fire) begin
                w_held_q <= 1'b1;
                wdata_q  <= s_axi_wdata;
                wstrb_q  <= s_axi_wstrb;
            end
            if (wr_exec) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_q && s_axi_bready) begin
                bvalid_q <= 1'b0;
                bresp_q  <= RESP_OKAY;
            end
        end
    end

    // Read channel: one-cycle latency, response held until accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_fire) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end
    end

    // Register file: reg0 only counts actions, the rest take AXI writes
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= (k == 1) ? DATA_WIDTH'(DONE_DELAY_DEFAULT) : '0;
            end
        end else begin
            if (count_inc) begin
                regs_q[0] <= count_d;
            end
            if (wr_exec && wr_in_range && (wr_idx != '0)) begin
                regs_q[wr_idx] <= wr_merged_d;
            end
        end
    end

    // Action controller: IDLE -> RUN (count down D) -> DONE -> IDLE on done_0a
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            go_0a_q   <= 1'b0;
            done_0r_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go_0r) begin
                        counter_q <= regs_q[1];
                        state_q   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (counter_q == '0) begin
                        state_q   <= ST_DONE;
                        go_0a_q   <= 1'b1;
                        done_0r_q <= 1'b1;
                    end else begin
                        counter_q <= counter_q - DATA_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    if (done_0a) begin
                        state_q   <= ST_IDLE;
                        go_0a_q   <= 1'b0;
                        done_0r_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    go_0a_q   <= 1'b0;
                    done_0r_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sda_kernel_action_stub_regs.sv
// Scoreboard bench for the stub kernel action: drivers push expected
// responses, a monitor pops and compares when the DUT presents them.
module tb_sda_kernel_action_stub_regs;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int NR        = 16;
    localparam int DEF_DELAY = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          go_0r = 1'b0;
    logic          go_0a;
    logic          done_0r;
    logic          done_0a = 1'b0;
    logic [AW-1:0] s_axi_araddr = '0;
    logic          s_axi_arvalid = 1'b0;
    logic          s_axi_arready;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rvalid;
    logic          s_axi_rready;
    logic [AW-1:0] s_axi_awaddr = '0;
    logic          s_axi_awvalid = 1'b0;
    logic          s_axi_awready;
    logic [DW-1:0] s_axi_wdata = '0;
    logic [3:0]    s_axi_wstrb = '0;
    logic          s_axi_wvalid = 1'b0;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready;

    sda_kernel_action_stub_regs #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .DONE_DELAY_DEFAULT(DEF_DELAY)
    ) dut (
        .clk(clk), .reset(reset),
        .go_0r(go_0r), .go_0a(go_0a), .done_0r(done_0r), .done_0a(done_0a),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic [1:0]  exp_b_q[$];
    rexp_t       exp_r_q[$];
    int unsigned exp_done_q[$];

    // Reference model: plain array of register values plus an action count
    logic [31:0] model_regs [NR];
    logic [31:0] model_count;

    int  b_seen = 0;
    int  r_seen = 0;
    int  b_stall_cnt = 0;
    int  r_stall_cnt = 0;
    bit  force_b_low = 0;
    bit  force_r_low = 0;
    bit  rand_bp = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NR; k++) model_regs[k] = 32'h0;
        model_regs[1] = DEF_DELAY;
        model_count = 32'h0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old & ~mask) | (nw & mask);
    endfunction

    // Ready generators: optional random backpressure or forced stalls
    initial begin
        s_axi_bready = 1'b1;
        s_axi_rready = 1'b1;
        forever begin
            @(negedge clk);
            s_axi_bready = force_b_low ? 1'b0 : (rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1);
            s_axi_rready = force_r_low ? 1'b0 : (rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1);
        end
    end

    // Monitor: compares responses and holds, sampled mid-cycle
    initial begin
        bit          b_stall = 0, r_stall = 0, done_prev = 0;
        logic [1:0]  b_prev = '0, r_prev_resp = '0;
        logic [31:0] r_prev_data = '0;
        logic [1:0]  eb;
        rexp_t       er;
        int unsigned ed;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                b_stall = 0; r_stall = 0; done_prev = 0;
            end else begin
                if (b_stall) begin
                    check("b_hold_valid", s_axi_bvalid, 1);
                    check("b_hold_resp", s_axi_bresp, b_prev);
                end
                if (s_axi_bvalid) check("aw_w_blocked", {s_axi_awready, s_axi_wready}, 0);
                if (s_axi_bvalid && s_axi_bready) begin
                    if (exp_b_q.size() == 0) fail_now("unexpected_bresp");
                    else begin
                        eb = exp_b_q.pop_front();
                        check("bresp", s_axi_bresp, eb);
                    end
                    b_seen++;
                end
                if (s_axi_bvalid && !s_axi_bready) b_stall_cnt++;
                b_stall = s_axi_bvalid && !s_axi_bready;
                b_prev  = s_axi_bresp;

                if (r_stall) begin
                    check("r_hold_valid", s_axi_rvalid, 1);
                    check("r_hold_data", s_axi_rdata, r_prev_data);
                    check("r_hold_resp", s_axi_rresp, r_prev_resp);
                end
                if (s_axi_rvalid) check("ar_blocked", s_axi_arready, 0);
                if (s_axi_rvalid && s_axi_rready) begin
                    if (exp_r_q.size() == 0) fail_now("unexpected_rdata");
                    else begin
                        er = exp_r_q.pop_front();
                        check("rdata", s_axi_rdata, er.data);
                        check("rresp", s_axi_rresp, er.resp);
                    end
                    r_seen++;
                end
                if (s_axi_rvalid && !s_axi_rready) r_stall_cnt++;
                r_stall     = s_axi_rvalid && !s_axi_rready;
                r_prev_data = s_axi_rdata;
                r_prev_resp = s_axi_rresp;

                if (done_0r && !done_prev) begin
                    if (exp_done_q.size() == 0) fail_now("unexpected_done");
                    else begin
                        ed = exp_done_q.pop_front();
                        check("done_edge", cyc, ed);
                    end
                    check("go_0a_with_done", go_0a, 1);
                end
                done_prev = done_0r;
            end
        end
    end

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly);
        int  n = 0;
        bit  aw_ok = 0, w_ok = 0, hs_aw, hs_w;
        int  target;
        logic [31:0] widx;
        widx = addr / 4;
        exp_b_q.push_back((widx < NR) ? 2'b00 : 2'b10);
        if (widx < NR && widx != 0) model_regs[widx] = merge(model_regs[widx], data, strb);
        target = b_seen + 1;
        while (!(aw_ok && w_ok) && n < 100) begin
            @(negedge clk);
            s_axi_awaddr  = addr;
            s_axi_wdata   = data;
            s_axi_wstrb   = strb;
            s_axi_awvalid = !aw_ok && (n >= aw_dly);
            s_axi_wvalid  = !w_ok && (n >= w_dly);
            hs_aw = s_axi_awvalid && s_axi_awready;
            hs_w  = s_axi_wvalid && s_axi_wready;
            @(posedge clk);
            if (hs_aw) aw_ok = 1;
            if (hs_w) w_ok = 1;
            n++;
        end
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        if (!(aw_ok && w_ok)) fail_now("write_addr_data_timeout");
        n = 0;
        while (b_seen < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (b_seen < target) fail_now("bresp_timeout");
        @(posedge clk);
    endtask

    task automatic read_drive(input logic [31:0] addr);
        int n = 0;
        bit ok = 0;
        int target;
        target = r_seen + 1;
        while (!ok && n < 100) begin
            @(negedge clk);
            s_axi_araddr  = addr;
            s_axi_arvalid = 1'b1;
            ok = s_axi_arready;
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        if (!ok) fail_now("read_addr_timeout");
        n = 0;
        while (r_seen < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (r_seen < target) fail_now("rdata_timeout");
        @(posedge clk);
    endtask

    // Read with an explicitly stated expected response
    task automatic axi_read_exp(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        rexp_t e;
        e.data = data;
        e.resp = resp;
        exp_r_q.push_back(e);
        read_drive(addr);
    endtask

    // Read whose expected response comes from the model
    task automatic axi_read(input logic [31:0] addr);
        rexp_t e;
        logic [31:0] ridx;
        ridx = addr / 4;
        if (ridx >= NR) begin
            e.data = 32'h0; e.resp = 2'b10;
        end else begin
            e.data = (ridx == 0) ? model_count : model_regs[ridx];
            e.resp = 2'b00;
        end
        exp_r_q.push_back(e);
        read_drive(addr);
    endtask

    // Program delay d, start an action and expect done_0r d+1 edges after go is taken
    task automatic run_action(input int d);
        int n = 0;
        axi_write(32'h4, d, 4'hF, 0, 0);
        @(negedge clk);
        go_0r = 1'b1;
        exp_done_q.push_back(cyc + 2 + d);
        @(negedge clk);
        go_0r = 1'b0;
        while (!done_0r && n < d + 50) begin
            @(negedge clk);
            n++;
        end
        if (!done_0r) fail_now("done_timeout");
        else begin
            done_0a = 1'b1;
            model_count = model_count + 1;
            @(negedge clk);
            done_0a = 1'b0;
            check("done_drops_after_ack", {go_0a, done_0r}, 2'b00);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_handshake_outs"},
              {go_0a, done_0r, s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_wready, s_axi_arready},
              7'b0000111);
        check({tag, "_data_outs"}, {s_axi_rdata, s_axi_rresp, s_axi_bresp}, 36'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [31:0] a, d;
        int op;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Reset values of the delay and count registers
        axi_read_exp(32'h4, DEF_DELAY, 2'b00);
        axi_read_exp(32'h0, 32'h0, 2'b00);
        check("idle_outs", {go_0a, done_0r}, 2'b00);

        // Delay of 10: done rises 11 edges after go is taken
        run_action(10);
        axi_read_exp(32'h0, 32'h1, 2'b00);

        // W leads AW by three cycles; then a partial-strobe write
        axi_write(32'hC, 32'h11223344, 4'hF, 3, 0);
        axi_read_exp(32'hC, 32'h11223344, 2'b00);
        axi_write(32'hC, 32'hAABBCCDD, 4'b0101, 0, 0);
        // bytes 0 and 2 take the new data
        axi_read_exp(32'hC, 32'h11BB33DD, 2'b00);

        // Out-of-range index and read-only count register
        axi_write(NR * 4, 32'hDEADBEEF, 4'hF, 0, 0);
        axi_read_exp(NR * 4, 32'h0, 2'b10);
        axi_read_exp(32'hC, 32'h11BB33DD, 2'b00);
        axi_write(32'h0, 32'h55, 4'hF, 0, 0);
        axi_read_exp(32'h0, 32'h1, 2'b00);

        // Response backpressure
        b_stall_cnt = 0;
        force_b_low = 1;
        fork
            begin repeat (8) @(negedge clk); force_b_low = 0; end
        join_none
        axi_write(32'h8, 32'hCAFEF00D, 4'hF, 0, 0);
        check("b_stall_cycles_ge5", b_stall_cnt >= 5, 1);
        r_stall_cnt = 0;
        force_r_low = 1;
        fork
            begin repeat (8) @(negedge clk); force_r_low = 0; end
        join_none
        axi_read(32'h8);
        check("r_stall_cycles_ge5", r_stall_cnt >= 5, 1);

        // Zero delay: exactly one RUN cycle
        run_action(0);
        axi_read_exp(32'h0, 32'h2, 2'b00);

        // Reset while an action is running
        axi_write(32'h4, 32'd50, 4'hF, 0, 0);
        @(negedge clk);
        go_0r = 1'b1;
        @(negedge clk);
        go_0r = 1'b0;
        repeat (10) @(negedge clk);
        check("running_no_done", done_0r, 0);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset_in_run");
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("idle_after_reset", {go_0a, done_0r}, 2'b00);
        axi_read_exp(32'h0, 32'h0, 2'b00);
        axi_read_exp(32'h4, DEF_DELAY, 2'b00);

        // Randomized traffic against the model
        rand_bp = 1;
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = ($urandom_range(0, NR + 3) * 4) + $urandom_range(0, 3);
            d = $urandom;
            if (op < 5) axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
            else if (op < 9) axi_read(a);
            else begin
                run_action($urandom_range(0, 12));
                axi_read(32'h0);
            end
        end
        rand_bp = 0;
        repeat (4) @(negedge clk);
        check("queues_drained", exp_b_q.size() + exp_r_q.size() + exp_done_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
